exu_mdu: RTL and testbench

- Iterative RV32M multiply/divide execute unit. It sits beside the single-cycle ALU in the EXU and handles the eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- It is generalised in operand width and in multiply step width.
- It uses valid/ready handshakes on both the issue and writeback sides, so the pipeline stalls while the unit is busy.

---
 rtl/exu_mdu_if.sv | 33 +++
 rtl/exu_mdu.sv | 146 ++++++++++++++
 tb/tb_exu_mdu.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_mdu_if.sv
// exu_mdu issue/writeback bundle.
// slave is the unit side, master is the issuing pipeline side.
interface exu_mdu_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_rd_wen;
    logic [4:0]      o_rd_addr;
    logic            o_busy;

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2,
        input  i_rd_addr, i_flush, i_ready,
        output o_ready, o_valid, o_result,
        output o_rd_wen, o_rd_addr, o_busy
    );

    modport master (
        output i_valid, i_op, i_rs1, i_rs2,
        output i_rd_addr, i_flush, i_ready,
        input  o_ready, o_valid, o_result,
        input  o_rd_wen, o_rd_addr, o_busy
    );
endinterface

// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, on operand magnitudes.
module exu_mdu #(
    parameter int XLEN       = 32,
    parameter int MUL_STEP   = 1,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic      clk,
    input  logic      rst,
    exu_mdu_if.slave  bus
);
    localparam int CW  = $clog2(XLEN + 1);
    localparam int PW  = XLEN + MUL_STEP;
    localparam int MCY = XLEN / MUL_STEP;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              a_neg, b_neg, bypass;
    logic [4:0]        rd_addr;

    logic              accept, in_div, sgn1, sgn2;
    logic              neg1, neg2, div0, ovf;
    logic [XLEN-1:0]   mag1, mag2, xmin;
    logic [PW-1:0]     psum;
    logic [XLEN:0]     rsh, diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;
    logic [XLEN-1:0]   quo, rem, res;

    assign xmin   = {1'b1, {(XLEN-1){1'b0}}};
    assign accept = bus.i_valid && bus.o_ready;
    assign in_div = bus.i_op[2];
    assign sgn1   = (bus.i_op == 3'd1) || (bus.i_op == 3'd2)
                 || (bus.i_op == 3'd4) || (bus.i_op == 3'd6);
    assign sgn2   = (bus.i_op == 3'd1) || (bus.i_op == 3'd4)
                 || (bus.i_op == 3'd6);
    assign neg1   = sgn1 && bus.i_rs1[XLEN-1];
    assign neg2   = sgn2 && bus.i_rs2[XLEN-1];
    assign mag1   = neg1 ? -bus.i_rs1 : bus.i_rs1;
    assign mag2   = neg2 ? -bus.i_rs2 : bus.i_rs2;
    assign div0   = in_div && (bus.i_rs2 == '0);
    assign ovf    = in_div && sgn2 && (bus.i_rs1 == xmin)
                 && (bus.i_rs2 == '1);

    // One multiply step: add opnd * low multiplier bits, shift right.
    assign psum   = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]}
                  + PW'(opnd) * PW'(acc[MUL_STEP-1:0]);
    assign mul_nx = {psum, acc[XLEN-1:MUL_STEP]};

    // One restoring step on {remainder, quotient}.
    assign rsh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff   = rsh - {1'b0, opnd};
    assign ge     = !diff[XLEN];
    assign div_nx = {ge ? diff[XLEN-1:0] : rsh[XLEN-1:0],
                     acc[XLEN-2:0], ge};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides everything but reset.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)
                      state_nx = (div0 || ovf) ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = DONE;
            DONE: if (bus.i_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.i_flush) state_nx = IDLE;
    end

    // Datapath: capture operands on accept, iterate in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op      <= '0;
            opnd    <= '0;
            acc     <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            bypass  <= 1'b0;
            rd_addr <= '0;
        end else if (accept) begin
            op      <= bus.i_op;
            rd_addr <= bus.i_rd_addr;
            a_neg   <= neg1;
            b_neg   <= neg2;
            bypass  <= div0 || ovf;
            if (!in_div) begin
                opnd <= mag1;
                acc  <= {{XLEN{1'b0}}, mag2};
                cnt  <= CW'(MCY);
            end else if (div0) begin
                opnd <= '0;
                acc  <= {bus.i_rs1, {XLEN{1'b1}}};
                cnt  <= '0;
            end else if (ovf) begin
                opnd <= '0;
                acc  <= {{XLEN{1'b0}}, xmin};
                cnt  <= '0;
            end else begin
                opnd <= mag2;
                acc  <= {{XLEN{1'b0}}, mag1};
                cnt  <= CW'(DIV_CYCLES);
            end
        end else if (state == CALC) begin
            acc <= op[2] ? div_nx : mul_nx;
            cnt <= cnt - CW'(1);
        end
    end

    assign prod = (a_neg ^ b_neg) ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    // Result select with sign correction; special cases bypass it.
    always_comb begin
        res = '0;
        unique case (1'b1)
            op == 3'd0:
                res = prod[XLEN-1:0];
            !op[2] && op != 3'd0:
                res = prod[2*XLEN-1:XLEN];
            op[2:1] == 2'b10:
                res = (bypass || !(a_neg ^ b_neg)) ? quo : -quo;
            default:
                res = (bypass || !a_neg) ? rem : -rem;
        endcase
    end

    assign bus.o_ready   = (state == IDLE) && !bus.i_flush;
    assign bus.o_valid   = (state == DONE);
    assign bus.o_rd_wen  = bus.o_valid;
    assign bus.o_rd_addr = rd_addr;
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_result  = bus.o_valid ? res : '0;
endmodule

// File: tb/tb_exu_mdu.sv
// Directed + scoreboard bench for exu_mdu.
// Drives two instances: MUL_STEP=1 and MUL_STEP=4.
module tb_exu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_op = '0;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic [4:0]  i_rd = '0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b1;

    logic        o_valid, o_ready, o_busy, o_wen;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    exu_mdu_if #(.XLEN(32)) bus1();
    exu_mdu_if #(.XLEN(32)) bus4();

    exu_mdu #(.XLEN(32), .MUL_STEP(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    exu_mdu #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );

    always #5 clk = ~clk;

    assign bus1.i_valid   = i_valid && !sel;
    assign bus4.i_valid   = i_valid && sel;
    assign bus1.i_op      = i_op;
    assign bus4.i_op      = i_op;
    assign bus1.i_rs1     = i_rs1;
    assign bus4.i_rs1     = i_rs1;
    assign bus1.i_rs2     = i_rs2;
    assign bus4.i_rs2     = i_rs2;
    assign bus1.i_rd_addr = i_rd;
    assign bus4.i_rd_addr = i_rd;
    assign bus1.i_flush   = i_flush;
    assign bus4.i_flush   = i_flush;
    assign bus1.i_ready   = i_ready;
    assign bus4.i_ready   = i_ready;

    assign o_valid  = sel ? bus4.o_valid   : bus1.o_valid;
    assign o_ready  = sel ? bus4.o_ready   : bus1.o_ready;
    assign o_busy   = sel ? bus4.o_busy    : bus1.o_busy;
    assign o_wen    = sel ? bus4.o_rd_wen  : bus1.o_rd_wen;
    assign o_result = sel ? bus4.o_result  : bus1.o_result;
    assign o_rd     = sel ? bus4.o_rd_addr : bus1.o_rd_addr;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h",
                    tag, obs, exp);
    endtask

    function automatic logic [31:0] model(logic [2:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] p;
        logic        ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin
                p = sa * longint'({32'b0, b});
                return p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(logic [2:0] op,
                                  logic [31:0] a,
                                  logic [31:0] b, logic s);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        if (op[2]) return 33;
        return s ? 9 : 33;
    endfunction

    // Issue one op, then wait for and score its result.
    task automatic run_op(string tag, logic s, logic [2:0] op,
                          logic [31:0] a, logic [31:0] b,
                          logic [4:0] rd, logic [31:0] exp_res);
        exp_t e;
        int   lat, busy_low;
        logic got;
        lat = lat_of(op, a, b, s);
        @(negedge clk);
        sel = s;
        i_ready = 1'b1;
        i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
        i_valid = 1'b1;
        exp_q.push_back('{res: exp_res, rd: rd, lat: lat});
        #1;
        chk({tag, ".ready"}, o_ready, 1'b1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        got = 1'b0;
        busy_low = 0;
        for (int c = 1; c <= lat + 3 && !got; c++) begin
            @(negedge clk);
            if (!o_busy) busy_low++;
            if (o_valid) begin
                e = exp_q.pop_front();
                chk({tag, ".result"}, o_result, e.res);
                chk({tag, ".rd"}, o_rd, e.rd);
                chk({tag, ".wen"}, o_wen, 1'b1);
                chk({tag, ".lat"}, c, e.lat);
                got = 1'b1;
            end
        end
        chk({tag, ".seen"}, got, 1'b1);
        chk({tag, ".busy"}, busy_low, 0);
        @(negedge clk);
        chk({tag, ".drop"}, o_valid, 1'b0);
        chk({tag, ".idle"}, o_ready, 1'b1);
        if (!got) exp_q.delete();
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          seen, waited;
        exp_t        e;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.valid", o_valid, 1'b0);
        chk("rst.wen", o_wen, 1'b0);
        chk("rst.result", o_result, 32'h0);
        chk("rst.rd", o_rd, 5'd0);
        chk("rst.busy", o_busy, 1'b0);
        chk("rst.ready", o_ready, 1'b1);

        run_op("mul", 0, 3'd0, 32'd7, 32'hFFFF_FFFD,
               5'd5, 32'hFFFF_FFEB);
        run_op("mulh", 0, 3'd1, 32'h8000_0000, 32'h8000_0000,
               5'd6, 32'h4000_0000);
        run_op("mulhu", 0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               5'd7, 32'hFFFF_FFFE);
        run_op("mulhsu", 0, 3'd2, 32'hFFFF_FFFF, 32'd2,
               5'd8, 32'hFFFF_FFFF);
        run_op("mul4", 1, 3'd0, 32'd7, 32'hFFFF_FFFD,
               5'd5, 32'hFFFF_FFEB);
        run_op("mulh4", 1, 3'd1, 32'h8000_0000, 32'h8000_0000,
               5'd6, 32'h4000_0000);
        run_op("mulhu4", 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               5'd7, 32'hFFFF_FFFE);
        run_op("mulhsu4", 1, 3'd2, 32'hFFFF_FFFF, 32'd2,
               5'd8, 32'hFFFF_FFFF);

        run_op("div", 0, 3'd4, 32'hFFFF_FFF9, 32'd2,
               5'd9, 32'hFFFF_FFFD);
        run_op("rem", 0, 3'd6, 32'hFFFF_FFF9, 32'd2,
               5'd10, 32'hFFFF_FFFF);
        run_op("divu", 0, 3'd5, 32'hFFFF_FFF9, 32'd2,
               5'd11, 32'h7FFF_FFFC);

        run_op("div0", 0, 3'd4, 32'd5, 32'd0,
               5'd12, 32'hFFFF_FFFF);
        run_op("remu0", 0, 3'd7, 32'd5, 32'd0,
               5'd13, 32'd5);
        run_op("divov", 0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               5'd14, 32'h8000_0000);
        run_op("remov", 0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
               5'd15, 32'h0);

        for (int k = 0; k < 12; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (k == 3) ? 32'd0 : $urandom;
            if (k % 4 == 1) rb = rb >> 20;
            run_op("rand", 1'(k % 2), rop, ra, rb, 5'(k + 1),
                   model(rop, ra, rb));
        end

        // Backpressure; a second issue waits for the handshake.
        @(negedge clk);
        sel = 0; i_ready = 1'b0;
        i_op = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7;
        i_rd = 5'd9; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        waited = 0;
        while (!o_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("bp.lat", waited, 33);
        for (int j = 1; j <= 5; j++) begin
            if (j == 2) begin
                i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4;
                i_rd = 5'd10; i_valid = 1'b1;
            end
            #1;
            chk("bp.result", o_result, 32'd14);
            chk("bp.rd", o_rd, 5'd9);
            chk("bp.ready", o_ready, 1'b0);
            chk("bp.valid", o_valid, 1'b1);
            @(negedge clk);
        end
        chk("bp.hold", o_result, 32'd14);
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp.drop", o_valid, 1'b0);
        chk("bp.idle", o_ready, 1'b1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        waited = 0;
        while (!o_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("bp2.lat", waited, 33);
        chk("bp2.result", o_result, 32'd12);
        chk("bp2.rd", o_rd, 5'd10);

        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        i_op = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3;
        i_rd = 5'd20; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (10) @(negedge clk);
        i_flush = 1'b1;
        #1 chk("fl.ready_lo", o_ready, 1'b0);
        @(posedge clk);
        #1 i_flush = 1'b0;
        @(negedge clk);
        chk("fl.ready", o_ready, 1'b1);
        chk("fl.busy", o_busy, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("fl.novalid", seen, 0);

        // Flush together with issue in IDLE.
        @(negedge clk);
        i_op = 3'd0; i_rs1 = 32'd2; i_rs2 = 32'd2;
        i_rd = 5'd21; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        chk("flacc.busy", o_busy, 1'b0);
        chk("flacc.rd", o_rd, 5'd20);

        // Reset mid-CALC.
        @(negedge clk);
        i_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9;
        i_rd = 5'd17; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rc.busy_pre", o_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rc.valid", o_valid, 1'b0);
        chk("rc.result", o_result, 32'h0);
        chk("rc.rd", o_rd, 5'd0);
        chk("rc.busy", o_busy, 1'b0);
        chk("rc.ready", o_ready, 1'b1);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("rc.novalid", seen, 0);
        chk("sb.empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
